// File: rtl/alu_pipe.sv
// Pipelined ALU with registered result and flags, valid/ready handshakes on
// both sides, and an optional iterative 1-bit-per-cycle shifter.
module alu_pipe #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ITER_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             of_detect,
    output logic             carry_detect,
    output logic             zero_detect,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned AW  = WIDTH + 1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_UADD = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [SHW-1:0]   count;
    logic [3:0]       sh_op;

    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             is_shift;
    logic             start_shift;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             add_of;

    logic [WIDTH-1:0] res;
    logic             res_of;
    logic             res_cy;
    logic             res_err;

    assign shamt       = in1[SHW-1:0];
    assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign is_shift    = (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
    assign start_shift = accept && (ITER_SHIFT != 0) && is_shift && (shamt != '0);

    // Shared adder: SUB is in0 + ~in1 + 1, UADD pre-shifts in0 by 12.
    always_comb begin
        add_a = in0;
        add_b = in1;
        cin   = 1'b0;
        case (op)
            OP_SUB: begin
                add_b = ~in1;
                cin   = 1'b1;
            end
            OP_UADD: add_a = {in0[WIDTH-13:0], 12'b0};
            default: ;
        endcase
        sum    = {1'b0, add_a} + {1'b0, add_b} + AW'(cin);
        add_of = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);
    end

    // Single-cycle result; in iterative mode the shifter only sees shamt == 0 here.
    always_comb begin
        res     = '0;
        res_of  = 1'b0;
        res_cy  = 1'b0;
        res_err = 1'b0;
        case (op)
            OP_AND:  res = in0 & in1;
            OP_OR:   res = in0 | in1;
            OP_NOR:  res = ~(in0 | in1);
            OP_XOR:  res = in0 ^ in1;
            OP_ADD, OP_SUB, OP_UADD: begin
                res    = sum[WIDTH-1:0];
                res_of = add_of;
                res_cy = sum[WIDTH];
            end
            OP_SRA:  res = (ITER_SHIFT != 0) ? in0 : WIDTH'($signed(in0) >>> shamt);
            OP_SRL:  res = (ITER_SHIFT != 0) ? in0 : (in0 >> shamt);
            OP_SLL:  res = (ITER_SHIFT != 0) ? in0 : (in0 << shamt);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(in0) < $signed(in1)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, in0 < in1};
            default: res_err = 1'b1;
        endcase
    end

    always_comb begin
        case (sh_op)
            OP_SRA:  work_next = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_SRL:  work_next = {1'b0, work[WIDTH-1:1]};
            default: work_next = {work[WIDTH-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            work         <= '0;
            count        <= '0;
            sh_op        <= '0;
            out_valid    <= 1'b0;
            out          <= '0;
            of_detect    <= 1'b0;
            carry_detect <= 1'b0;
            zero_detect  <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_shift) begin
                        work  <= in0;
                        count <= shamt;
                        sh_op <= op;
                        state <= SHIFT;
                    end else if (accept) begin
                        out          <= res;
                        of_detect    <= res_of;
                        carry_detect <= res_cy;
                        zero_detect  <= (res == '0);
                        err          <= res_err;
                        out_valid    <= 1'b1;
                    end
                end
                SHIFT: begin
                    work  <= work_next;
                    count <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        out          <= work_next;
                        of_detect    <= 1'b0;
                        carry_detect <= 1'b0;
                        zero_detect  <= (work_next == '0);
                        err          <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a single-cycle instance and an iterative-shift instance
// share operands; results are checked against an arithmetic reference model.
module tb_alu_pipe;

    localparam int unsigned W = 32;
    localparam longint SMAX = (longint'(1) <<< 31) - 1;
    localparam longint SMIN = -(longint'(1) <<< 31);
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv0, iv1, ordy;
    logic [W-1:0] a, b;
    logic [3:0]   op;

    logic         rdy0, ov0, of0, cy0, z0, er0;
    logic [W-1:0] o0;
    logic         rdy1, ov1, of1, cy1, z1, er1;
    logic [W-1:0] o1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .ITER_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .in0(a), .in1(b), .op(op),
        .out_valid(ov0), .out_ready(ordy), .out(o0), .of_detect(of0),
        .carry_detect(cy0), .zero_detect(z0), .err(er0)
    );

    alu_pipe #(.WIDTH(W), .ITER_SHIFT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in0(a), .in1(b), .op(op),
        .out_valid(ov1), .out_ready(ordy), .out(o1), .of_detect(of1),
        .carry_detect(cy1), .zero_detect(z1), .err(er1)
    );

    typedef struct packed {
        logic [W-1:0] out;
        logic         of;
        logic         cy;
        logic         z;
        logic         err;
    } res_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        res_t         e;
    } vec_t;

    function automatic logic ovf(input longint r);
        return (r > SMAX) || (r < SMIN);
    endfunction

    // Reference: the operation's meaning in 64-bit integer arithmetic.
    function automatic res_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t m;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint unsigned t;
        longint unsigned ua;
        int sh = int'(y[4:0]);
        m = '0;
        case (o)
            4'd0: m.out = x & y;
            4'd1: m.out = x | y;
            4'd2: begin
                t = ux + uy;
                m.out = W'(t);
                m.cy = (t >= MOD);
                m.of = ovf(sx + sy);
            end
            4'd3: begin
                m.out = W'(ux - uy);
                m.cy = (ux >= uy);
                m.of = ovf(sx - sy);
            end
            4'd4: m.out = W'(sx >>> sh);
            4'd5: m.out = ~(x | y);
            4'd6: m.out = W'(ux >> sh);
            4'd7: m.out = W'(ux << sh);
            4'd8: begin
                ua = (ux * 64'd4096) % MOD;
                t = ua + uy;
                m.out = W'(t);
                m.cy = (t >= MOD);
                m.of = ovf(longint'($signed(W'(ua))) + sy);
            end
            4'd9:  m.out = x ^ y;
            4'd10: m.out = (sx < sy) ? W'(1) : W'(0);
            4'd11: m.out = (ux < uy) ? W'(1) : W'(0);
            default: m.err = 1'b1;
        endcase
        m.z = (m.out == '0);
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res0(input string n, input res_t e);
        chk({n, " valid"}, 64'(ov0), 64'(1));
        chk({n, " out"},   64'(o0),  64'(e.out));
        chk({n, " of"},    64'(of0), 64'(e.of));
        chk({n, " carry"}, 64'(cy0), 64'(e.cy));
        chk({n, " zero"},  64'(z0),  64'(e.z));
        chk({n, " err"},   64'(er0), 64'(e.err));
    endtask

    // Issue one shift to the iterative instance; expect shamt busy cycles.
    task automatic run_shift(input string n, input logic [3:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] exp);
        int s = int'(y[4:0]);
        op = o; a = x; b = y; iv1 = 1'b1;
        #1;
        chk({n, " ready"}, 64'(rdy1), 64'(1));
        step();
        iv1 = 1'b0;
        for (int k = 0; k < s; k++) begin
            chk({n, " busy"}, 64'(rdy1), 64'(0));
            step();
        end
        chk({n, " valid"}, 64'(ov1), 64'(1));
        chk({n, " out"},   64'(o1),  64'(exp));
        chk({n, " zero"},  64'(z1),  64'(exp == '0));
        chk({n, " flags"}, 64'({of1, cy1, er1}), 64'(0));
    endtask

    vec_t vecs[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{4'd3,  32'h0000_0005, 32'h0000_0005, '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[2]  = '{4'd3,  32'h0000_0000, 32'h0000_0001, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{4'd13, 32'h0000_1234, 32'h0000_0055, '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1}};
        vecs[4]  = '{4'd8,  32'h0000_0012, 32'h0000_0345, '{32'h0001_2345, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[6]  = '{4'd11, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[7]  = '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[8]  = '{4'd4,  32'h8000_0000, 32'h0000_0025, '{32'hFC00_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[9]  = '{4'd7,  32'h0000_0001, 32'h0000_001F, '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{4'd5,  32'h0000_0000, 32'h0000_0000, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[11] = '{4'd3,  32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0}};

        rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; ordy = 1'b1;
        a = '0; b = '0; op = '0;
        step();
        step();
        chk("reset valid0", 64'(ov0), 64'(0));
        chk("reset out0",   64'(o0),  64'(0));
        chk("reset flags0", 64'({of0, cy0, z0, er0}), 64'(0));
        chk("reset valid1", 64'(ov1), 64'(0));
        chk("reset flags1", 64'({o1, of1, cy1, z1, er1}), 64'(0));
        rst = 1'b0;
        #1;
        chk("reset ready0", 64'(rdy0), 64'(1));
        chk("reset ready1", 64'(rdy1), 64'(1));

        // Directed vectors, issued back-to-back.
        for (int i = 0; i < 12; i++) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; iv0 = 1'b1;
            #1;
            chk($sformatf("vec%0d ready", i), 64'(rdy0), 64'(1));
            step();
            chk_res0($sformatf("vec%0d", i), vecs[i].e);
        end
        iv0 = 1'b0;
        step();
        chk("drain valid", 64'(ov0), 64'(0));

        // Random single-cycle traffic against the model.
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 3)) << 30;
            iv0 = 1'b1;
            step();
            chk_res0($sformatf("rand%0d op%0d", i, op), model(op, a, b));
        end
        iv0 = 1'b0;
        step();

        // Backpressure: result held, new input refused, then simultaneous transfers.
        ordy = 1'b0;
        op = 4'd2; a = 32'd3; b = 32'd4; iv0 = 1'b1;
        step();
        op = 4'd2; a = 32'd100; b = 32'd100;
        chk("stall first", 64'(o0), 64'(7));
        for (int k = 0; k < 3; k++) begin
            chk("stall ready", 64'(rdy0), 64'(0));
            step();
            chk("stall valid", 64'(ov0), 64'(1));
            chk("stall out",   64'(o0),  64'(7));
        end
        op = 4'd9; a = 32'h0000_00F0; b = 32'h0000_000F; ordy = 1'b1;
        #1;
        chk("release ready", 64'(rdy0), 64'(1));
        step();
        iv0 = 1'b0;
        chk("replace valid", 64'(ov0), 64'(1));
        chk("replace out",   64'(o0),  64'(32'h0000_00FF));
        step();
        chk("consumed valid", 64'(ov0), 64'(0));

        // Iterative shifter.
        run_shift("sra4",  4'd4, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
        run_shift("sra5",  4'd4, 32'h8000_0000, 32'h0000_0025, 32'hFC00_0000);
        run_shift("sh0",   4'd6, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF);
        run_shift("sll31", 4'd7, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000);
        run_shift("srlz",  4'd6, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
        for (int i = 0; i < 40; i++) begin
            logic [3:0]   ro;
            logic [W-1:0] ra, rb;
            int sel = $urandom_range(0, 2);
            ro = (sel == 0) ? 4'd4 : (sel == 1) ? 4'd6 : 4'd7;
            ra = $urandom;
            rb = $urandom;
            run_shift($sformatf("rshift%0d", i), ro, ra, rb, model(ro, ra, rb).out);
        end

        // Reset in the second SHIFT cycle aborts without a result.
        op = 4'd4; a = 32'h8000_0000; b = 32'd10; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("abort valid", 64'(ov1), 64'(0));
        chk("abort out",   64'(o1),  64'(0));
        chk("abort flags", 64'({of1, cy1, z1, er1}), 64'(0));
        rst = 1'b0;
        #1;
        chk("abort ready", 64'(rdy1), 64'(1));
        for (int k = 0; k < 12; k++) begin
            step();
            chk("abort no result", 64'(ov1), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
